buffer_resultado: RTL and testbench
===================================

BUFFER_RESULTADO -- requirements
Module: buffer_resultado

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the result data width (the Q width of the upstream Sumador8).
REQ-002 SHALL have parameter DEPTH, default 4, giving the number of entries, a power of two of at least 2.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state changes occur on the rising edge.
REQ-004 SHALL have port RESET_N, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port IN_VALID, input, 1 bit: the upstream adder presents a new result this cycle.
REQ-006 SHALL have port Q_IN, input, WIDTH bits: result from the adder's Q.
REQ-007 SHALL have port RCO_IN, input, 1 bit: carry-out from the adder's RCO.
REQ-008 SHALL have port MODO_IN, input, 2 bits: operation mode that produced the result.
REQ-009 SHALL have port OUT_READY, input, 1 bit: the downstream consumer accepts the head entry.
REQ-010 SHALL have port OUT_VALID, output, 1 bit: the head entry is valid.
REQ-011 SHALL have port OUT_DATA, output, WIDTH+1 bits: the head entry as {RCO, Q}.
REQ-012 SHALL have port OUT_MODO, output, 2 bits: the head entry's mode.
REQ-013 SHALL have port FULL, output, 1 bit: the buffer is full.
REQ-014 SHALL have port EMPTY, output, 1 bit: the buffer is empty.
REQ-015 SHALL have port COUNT, output, log2(DEPTH)+1 bits: number of stored entries.
REQ-016 SHALL have port DROP_CNT, output, 8 bits: saturating count of results lost to overflow.
REQ-017 SHALL have port RCO_CNT, output, 8 bits: saturating count of accepted entries with RCO_IN=1.

Function
REQ-018 SHALL form each entry as {MODO_IN, RCO_IN, Q_IN} and store entries in a circular buffer with read and write pointers that wrap modulo DEPTH.
REQ-019 SHALL define a push as IN_VALID=1 and (FULL=0 or a pop in the same cycle).
REQ-020 SHALL define a pop as OUT_VALID=1 and OUT_READY=1.
REQ-021 SHALL update COUNT by +1 on a push only, by -1 on a pop only, and leave it unchanged on a simultaneous push and pop.
REQ-022 SHALL drive EMPTY=(COUNT==0), FULL=(COUNT==DEPTH) and OUT_VALID=~EMPTY.
REQ-023 SHALL present the head entry on OUT_DATA/OUT_MODO (first-word fall-through) whenever OUT_VALID=1, and drive both to 0 when EMPTY=1.
REQ-024 SHALL make a push into an empty buffer visible at the output one cycle after the push edge, with no same-cycle bypass.
REQ-025 SHALL, when IN_VALID=1, FULL=1 and OUT_READY=0, leave the contents unchanged and increment DROP_CNT, saturating at 255.
REQ-026 SHALL, when IN_VALID=1, FULL=1 and OUT_READY=1, pop the head and push the new entry in the same cycle, keeping COUNT=DEPTH and not incrementing DROP_CNT.
REQ-027 SHALL increment RCO_CNT on each push with RCO_IN=1, saturating at 255; dropped results SHALL NOT be counted.
REQ-028 SHALL treat OUT_READY=1 while EMPTY=1 as a no-op, with no pointer movement.
REQ-029 SHALL ignore Q_IN, RCO_IN and MODO_IN whenever IN_VALID=0.

Reset
REQ-030 SHALL, while RESET_N=0 and independent of CLK, clear both pointers and COUNT, DROP_CNT and RCO_CNT to 0, and drive EMPTY=1, FULL=0, OUT_VALID=0, OUT_DATA=0 and OUT_MODO=0.
REQ-031 SHALL discard all stored entries when reset is asserted mid-operation, and report none after release.
REQ-032 SHALL process its first push on the first rising CLK edge on which RESET_N=1.
REQ-033 SHALL NOT require reset of the storage array contents; unread storage SHALL never be visible on OUT_DATA.

Verification
REQ-034 Bench SHALL cover single push then pop: push Q_IN=0x5A, RCO_IN=1, MODO_IN=2 -> next cycle OUT_VALID=1, OUT_DATA=0x15A, OUT_MODO=2, COUNT=1, RCO_CNT=1; then OUT_READY=1 -> EMPTY=1, OUT_DATA=0.
REQ-035 Bench SHALL cover fill to full: push 0x01..0x04 with OUT_READY=0 -> FULL=1, COUNT=4; a 5th push of 0x05 -> DROP_CNT=1; pop order 0x01, 0x02, 0x03, 0x04.
REQ-036 Bench SHALL cover simultaneous push and pop at full: FULL=1, IN_VALID=1, OUT_READY=1, Q_IN=0x99 -> COUNT stays 4, DROP_CNT unchanged, and 0x99 is popped last.
REQ-037 Bench SHALL cover pointer wrap-around: 10 push/pop pairs with OUT_READY=1 and values 0x10..0x19 -> output sequence 0x10..0x19 in order, COUNT≤1 throughout.
REQ-038 Bench SHALL cover saturation: 300 dropped pushes while full -> DROP_CNT=255; 300 accepted pushes with RCO_IN=1 -> RCO_CNT=255.
REQ-039 Bench SHALL cover reset mid-operation: with COUNT=3, assert RESET_N=0 between clock edges -> EMPTY=1, COUNT=0, OUT_VALID=0 immediately; after release the first pop returns only newly pushed data.

Source files
------------

// File: rtl/buffer_resultado.sv
`default_nettype none
// ============================================================================
// Module      : buffer_resultado
// Description : First-word fall-through circular buffer for adder results.
//               Each entry holds {MODO, RCO, Q}. Overflow either drops the
//               new result (counted in DROP_CNT) or, when the consumer is
//               ready in the same cycle, pops the head and stores the new one.
// Revision    : 1.0 - initial release
// ============================================================================
module buffer_resultado #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     RESET_N,
   input  logic                     IN_VALID,
   input  logic [WIDTH-1:0]         Q_IN,
   input  logic                     RCO_IN,
   input  logic [1:0]               MODO_IN,
   input  logic                     OUT_READY,
   output logic                     OUT_VALID,
   output logic [WIDTH:0]           OUT_DATA,
   output logic [1:0]               OUT_MODO,
   output logic                     FULL,
   output logic                     EMPTY,
   output logic [$clog2(DEPTH):0]   COUNT,
   output logic [7:0]               DROP_CNT,
   output logic [7:0]               RCO_CNT
);

   localparam int c_addr_w  = $clog2(DEPTH);
   localparam int c_entry_w = WIDTH + 3;
   localparam logic [c_addr_w:0] c_full_count = (c_addr_w + 1)'(DEPTH);

   // Storage is deliberately not reset; COUNT gates every read of it.
   logic [c_entry_w-1:0] r_mem [DEPTH];
   logic [c_addr_w-1:0]  r_wr_ptr;
   logic [c_addr_w-1:0]  r_rd_ptr;
   logic [c_addr_w:0]    r_count;
   logic [7:0]           r_drop_cnt;
   logic [7:0]           r_rco_cnt;

   logic                 w_empty;
   logic                 w_full;
   logic                 w_pop;
   logic                 w_push;
   logic                 w_drop;
   logic [c_entry_w-1:0] w_head;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == c_full_count);

   // A pop needs a valid head; a push at full is only allowed alongside a pop.
   assign w_pop   = ~w_empty & OUT_READY;
   assign w_push  = IN_VALID & (~w_full | w_pop);
   assign w_drop  = IN_VALID & w_full & ~OUT_READY;

   assign w_head  = r_mem[r_rd_ptr];

   assign EMPTY     = w_empty;
   assign FULL      = w_full;
   assign OUT_VALID = ~w_empty;
   assign COUNT     = r_count;
   assign DROP_CNT  = r_drop_cnt;
   assign RCO_CNT   = r_rco_cnt;

   // Outputs are forced to zero when empty so stale storage never leaks out.
   assign OUT_DATA  = w_empty ? '0 : w_head[WIDTH:0];
   assign OUT_MODO  = w_empty ? 2'b00 : w_head[WIDTH+2:WIDTH+1];

   // Write accepted entries into the array at the write pointer.
   always_ff @(posedge CLK) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {MODO_IN, RCO_IN, Q_IN};
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH = 2^n).
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Saturating statistics: lost results and accepted results carrying RCO.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_drop_cnt <= '0;
         r_rco_cnt  <= '0;
      end else begin
         if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
         end
         if (w_push && RCO_IN && (r_rco_cnt != 8'hFF)) begin
            r_rco_cnt <= r_rco_cnt + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_buffer_resultado.sv
`default_nettype none
// ============================================================================
// Module      : tb_buffer_resultado
// Description : Directed bench for buffer_resultado with a queue scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_buffer_resultado;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;

   typedef logic [WIDTH+2:0] entry_t;

   logic         CLK;
   logic         RESET_N;
   logic         IN_VALID;
   logic [7:0]   Q_IN;
   logic         RCO_IN;
   logic [1:0]   MODO_IN;
   logic         OUT_READY;
   logic         OUT_VALID;
   logic [8:0]   OUT_DATA;
   logic [1:0]   OUT_MODO;
   logic         FULL;
   logic         EMPTY;
   logic [2:0]   COUNT;
   logic [7:0]   DROP_CNT;
   logic [7:0]   RCO_CNT;

   buffer_resultado #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .IN_VALID  (IN_VALID),
      .Q_IN      (Q_IN),
      .RCO_IN    (RCO_IN),
      .MODO_IN   (MODO_IN),
      .OUT_READY (OUT_READY),
      .OUT_VALID (OUT_VALID),
      .OUT_DATA  (OUT_DATA),
      .OUT_MODO  (OUT_MODO),
      .FULL      (FULL),
      .EMPTY     (EMPTY),
      .COUNT     (COUNT),
      .DROP_CNT  (DROP_CNT),
      .RCO_CNT   (RCO_CNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int     n_checks = 0;
   int     n_pass   = 0;
   entry_t sb[$];
   int     m_drop   = 0;
   int     m_rco    = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Compare every visible output against the scoreboard model.
   task automatic check_state();
      entry_t head;
      chk("count", COUNT, sb.size());
      chk("empty", EMPTY, sb.size() == 0);
      chk("full", FULL, sb.size() == DEPTH);
      chk("out_valid", OUT_VALID, sb.size() != 0);
      chk("drop_cnt", DROP_CNT, m_drop);
      chk("rco_cnt", RCO_CNT, m_rco);
      if (sb.size() == 0) begin
         chk("data_zero", OUT_DATA, 0);
         chk("modo_zero", OUT_MODO, 0);
      end else begin
         head = sb[0];
         chk("head_data", OUT_DATA, head[8:0]);
         chk("head_modo", OUT_MODO, head[10:9]);
      end
   endtask

   // Drive one cycle of stimulus; pops are compared against the queue head.
   task automatic step(input logic iv, input logic [7:0] q, input logic rco,
                       input logic [1:0] modo, input logic rdy);
      entry_t head;
      bit     pop;
      bit     push;
      bit     drop;
      IN_VALID  = iv;
      Q_IN      = q;
      RCO_IN    = rco;
      MODO_IN   = modo;
      OUT_READY = rdy;
      pop  = (sb.size() > 0) && rdy;
      push = iv && ((sb.size() < DEPTH) || pop);
      drop = iv && (sb.size() == DEPTH) && !rdy;
      if (pop) begin
         head = sb[0];
         chk("pop_data", OUT_DATA, head[8:0]);
         chk("pop_modo", OUT_MODO, head[10:9]);
      end
      @(posedge CLK);
      #1;
      if (pop) void'(sb.pop_front());
      if (push) begin
         sb.push_back({modo, rco, q});
         if (rco && m_rco < 255) m_rco++;
      end
      if (drop && m_drop < 255) m_drop++;
      check_state();
   endtask

   initial begin
      RESET_N   = 1'b0;
      IN_VALID  = 1'b0;
      Q_IN      = '0;
      RCO_IN    = 1'b0;
      MODO_IN   = '0;
      OUT_READY = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check_state();
      #2 RESET_N = 1'b1;

      // Single push then pop
      step(1'b1, 8'h5A, 1'b1, 2'd2, 1'b0);
      chk("single_data", OUT_DATA, 9'h15A);
      chk("single_modo", OUT_MODO, 2);
      chk("single_count", COUNT, 1);
      chk("single_rco", RCO_CNT, 1);
      step(1'b0, 8'h00, 1'b0, 2'd0, 1'b1);
      chk("single_empty", EMPTY, 1);
      chk("single_zero", OUT_DATA, 0);

      // Fill to full, drop one, drain in order
      for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 2'(i), 1'b0);
      chk("fill_full", FULL, 1);
      chk("fill_count", COUNT, 4);
      step(1'b1, 8'h05, 1'b0, 2'd0, 1'b0);
      chk("fill_drop", DROP_CNT, 1);
      for (int i = 1; i <= 4; i++) begin
         chk("fill_order", OUT_DATA[7:0], i);
         step(1'b0, 8'h00, 1'b0, 2'd0, 1'b1);
      end

      // Simultaneous push and pop at full
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h21 + i), 1'b0, 2'd1, 1'b0);
      step(1'b1, 8'h99, 1'b0, 2'd3, 1'b1);
      chk("pp_count", COUNT, 4);
      chk("pp_drop", DROP_CNT, 1);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 2'd0, 1'b1);
      chk("pp_last", OUT_DATA[7:0], 8'h99);
      step(1'b0, 8'h00, 1'b0, 2'd0, 1'b1);

      // Pointer wrap with continuous push/pop
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 8'(8'h10 + i), 1'b0, 2'd1, 1'b1);
         chk("wrap_count_le1", COUNT <= 1, 1);
      end
      step(1'b0, 8'h00, 1'b0, 2'd0, 1'b1);

      // Inputs ignored while IN_VALID is low
      step(1'b0, 8'hFF, 1'b1, 2'd3, 1'b0);

      // Reset in the middle of a cycle with three stored entries
      for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h31 + i), 1'b0, 2'd2, 1'b0);
      chk("mid_count3", COUNT, 3);
      #3 RESET_N = 1'b0;
      #1;
      sb.delete();
      m_drop = 0;
      m_rco  = 0;
      chk("rst_empty", EMPTY, 1);
      chk("rst_count", COUNT, 0);
      chk("rst_valid", OUT_VALID, 0);
      check_state();
      @(posedge CLK);
      #3 RESET_N = 1'b1;
      step(1'b1, 8'h77, 1'b0, 2'd1, 1'b0);
      chk("rst_new", OUT_DATA[7:0], 8'h77);
      step(1'b0, 8'h00, 1'b0, 2'd0, 1'b1);

      // Saturation of both statistics counters
      for (int i = 0; i < 4; i++) step(1'b1, 8'(i), 1'b1, 2'd0, 1'b0);
      repeat (300) step(1'b1, 8'hAA, 1'b1, 2'd0, 1'b0);
      chk("sat_drop", DROP_CNT, 255);
      chk("sat_rco_hold", RCO_CNT, 4);
      repeat (300) step(1'b1, 8'hBB, 1'b1, 2'd2, 1'b1);
      chk("sat_rco", RCO_CNT, 255);
      chk("sat_drop_hold", DROP_CNT, 255);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
